// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: FSM states, PC-mux select, NOP and reset PC.
// imem handshake: a beat transfers when imem_req && imem_ready in the same cycle; while imem_req is high without imem_ready, imem_addr holds.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        SKID  = 2'd1,
        KILL  = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_e;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Fetch PC register with its hold / increment / load next-PC mux.
module pc_reg
    import cpu_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            pc_sel_i,
    input  logic [DATA_WIDTH-1:0] load_pc_i,
    output logic [DATA_WIDTH-1:0] pc_o
);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;

    // Increment wraps naturally at the top of the address space.
    always_comb begin
        pc_d = pc_q;
        case (pc_sel_i)
            PC_INC:  pc_d = pc_q + DATA_WIDTH'(4);
            PC_LOAD: pc_d = load_pc_i;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem request, one-entry skid buffer, F->D pipeline registers.
// KILL remembers a redirect that arrived while a request was still waiting for imem_ready.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_d,
    input  logic                  flush_d,
    input  logic                  pc_src_e,
    input  logic [DATA_WIDTH-1:0] pc_target_e,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] pc_plus4_d,
    output logic                  valid_d,
    output logic [1:0]            fsm_state
);

    localparam logic [DATA_WIDTH-1:0] NOP_W = DATA_WIDTH'(NOP);

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] instr_d_q, instr_d_d;
    logic [DATA_WIDTH-1:0] pc_d_q, pc_d_d;
    logic                  valid_d_q, valid_d_d;
    logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [DATA_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_WIDTH-1:0] kill_tgt_q, kill_tgt_d;
    logic [DATA_WIDTH-1:0] pc_f, pc_load, tgt_aligned;
    pc_sel_e               pc_sel;
    logic                  xfer;

    pc_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_sel_i  (pc_sel),
        .load_pc_i (pc_load),
        .pc_o      (pc_f)
    );

    // Gated with rst_n so the request drops the moment reset asserts.
    assign imem_req    = rst_n && (state_q != SKID);
    assign imem_addr   = pc_f;
    assign xfer        = imem_req && imem_ready;
    assign tgt_aligned = pc_target_e & ~DATA_WIDTH'(3);

    always_comb begin
        state_d      = state_q;
        instr_d_d    = instr_d_q;
        pc_d_d       = pc_d_q;
        valid_d_d    = valid_d_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        kill_tgt_d   = kill_tgt_q;
        pc_sel       = PC_HOLD;
        pc_load      = tgt_aligned;

        if (pc_src_e) begin
            valid_d_d    = 1'b0;
            instr_d_d    = NOP_W;
            skid_instr_d = NOP_W;
            skid_pc_d    = '0;
            if (imem_req && !imem_ready) begin
                kill_tgt_d = tgt_aligned;
                state_d    = KILL;
            end else begin
                pc_sel  = PC_LOAD;
                state_d = FETCH;
            end
        end else if (flush_d) begin
            valid_d_d    = 1'b0;
            instr_d_d    = NOP_W;
            skid_instr_d = NOP_W;
            skid_pc_d    = '0;
            // A pending redirect still has to land even while decode flushes.
            if (state_q == KILL) begin
                if (xfer) begin
                    pc_sel  = PC_LOAD;
                    pc_load = kill_tgt_q;
                    state_d = FETCH;
                end
            end else begin
                state_d = FETCH;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (xfer && !stall_d) begin
                        instr_d_d = imem_rdata;
                        pc_d_d    = pc_f;
                        valid_d_d = 1'b1;
                        pc_sel    = PC_INC;
                    end else if (xfer) begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_f;
                        pc_sel       = PC_INC;
                        state_d      = SKID;
                    end else if (!stall_d) begin
                        valid_d_d = 1'b0;
                        instr_d_d = NOP_W;
                    end
                end
                SKID: begin
                    if (!stall_d) begin
                        instr_d_d    = skid_instr_q;
                        pc_d_d       = skid_pc_q;
                        valid_d_d    = 1'b1;
                        skid_instr_d = NOP_W;
                        skid_pc_d    = '0;
                        state_d      = FETCH;
                    end
                end
                KILL: begin
                    if (xfer) begin
                        pc_sel  = PC_LOAD;
                        pc_load = kill_tgt_q;
                        state_d = FETCH;
                    end
                    if (!stall_d) begin
                        valid_d_d = 1'b0;
                        instr_d_d = NOP_W;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            instr_d_q    <= NOP_W;
            pc_d_q       <= '0;
            valid_d_q    <= 1'b0;
            skid_instr_q <= NOP_W;
            skid_pc_q    <= '0;
            kill_tgt_q   <= '0;
        end else begin
            state_q      <= state_d;
            instr_d_q    <= instr_d_d;
            pc_d_q       <= pc_d_d;
            valid_d_q    <= valid_d_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            kill_tgt_q   <= kill_tgt_d;
        end
    end

    assign instr_d    = instr_d_q;
    assign pc_d       = pc_d_q;
    assign pc_plus4_d = pc_d_q + DATA_WIDTH'(4);
    assign valid_d    = valid_d_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, all checked against a
// transaction-level model (pending-redirect flag, skid queue, D-stage slot).
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall_d = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0, imem_ready = 1'b0;
    logic [31:0] pc_target_e = '0, imem_rdata = '0;
    logic        imem_req, valid_d;
    logic [31:0] imem_addr, instr_d, pc_d, pc_plus4_d;
    logic [1:0]  fsm_state;

    int tests = 0;
    int fails = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } slot_t;

    slot_t       skid_q[$];
    logic [31:0] m_pc, m_instr, m_pcd, m_tgt;
    bit          m_valid, m_kill;

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = NOP;
        m_pcd   = 32'h0;
        m_valid = 1'b0;
        m_kill  = 1'b0;
        m_tgt   = 32'h0;
        skid_q.delete();
    endtask

    function automatic bit m_req();
        return (skid_q.size() == 0);
    endfunction

    task automatic m_bubble();
        m_valid = 1'b0;
        m_instr = NOP;
    endtask

    task automatic model_update(input bit st, input bit fl, input bit rd, input logic [31:0] tg,
                                input bit rdy, input logic [31:0] data);
        bit    req, xfer;
        slot_t s;
        req  = m_req();
        xfer = req && rdy;
        if (rd) begin
            m_bubble();
            skid_q.delete();
            if (req && !rdy) begin
                m_kill = 1'b1;
                m_tgt  = tg;
            end else begin
                m_kill = 1'b0;
                m_pc   = tg;
            end
        end else if (fl) begin
            m_bubble();
            skid_q.delete();
            if (m_kill && xfer) begin
                m_pc   = m_tgt;
                m_kill = 1'b0;
            end
        end else if (skid_q.size() != 0) begin
            if (!st) begin
                s       = skid_q.pop_front();
                m_instr = s.instr;
                m_pcd   = s.pc;
                m_valid = 1'b1;
            end
        end else if (m_kill) begin
            if (xfer) begin
                m_pc   = m_tgt;
                m_kill = 1'b0;
            end
            if (!st) m_bubble();
        end else if (xfer) begin
            if (st) begin
                skid_q.push_back('{instr: data, pc: m_pc});
            end else begin
                m_instr = data;
                m_pcd   = m_pc;
                m_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_bubble();
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
        check("imem_addr", imem_addr, m_pc);
        check("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
        check("instr_d", instr_d, m_instr);
        check("pc_d", pc_d, m_pcd);
        check("pc_plus4_d", pc_plus4_d, m_pcd + 32'd4);
    endtask

    // ---------------- drivers ----------------
    // Called at a negedge: drive, compare, advance the model, return at the next negedge.
    task automatic step(input bit st, input bit fl, input bit rd, input logic [31:0] tg,
                        input bit rdy, input logic [31:0] data);
        stall_d     = st;
        flush_d     = fl;
        pc_src_e    = rd;
        pc_target_e = tg;
        imem_ready  = rdy;
        imem_rdata  = data;
        #1;
        check_model();
        model_update(st, fl, rd, tg & ~32'h3, rdy, data);
        @(negedge clk);
    endtask

    task automatic fetch_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, $urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, valid_d}, 32'h0);
        check("rst_instr", instr_d, NOP);
        check("rst_pc_d", pc_d, 32'h0);
        check("rst_plus4", pc_plus4_d, 32'h4);
        stall_d    = 1'b0;
        flush_d    = 1'b0;
        pc_src_e   = 1'b0;
        imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1;
        do_reset();

        // zero-wait stream
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1000 + k);
            check("zw_pc_d", pc_d, 32'(4 * (k - 1)));
            check("zw_valid", {31'b0, valid_d}, 32'h1);
        end

        // three wait cycles at 0x8
        do_reset();
        fetch_n(2);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, $urandom);
            check("wait_addr", imem_addr, 32'h8);
            check("wait_valid", {31'b0, valid_d}, 32'h0);
            check("wait_instr", instr_d, NOP);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0008);
        check("wait_pc_d", pc_d, 32'h8);
        check("wait_data", instr_d, 32'hCAFE_0008);

        // stall during the 0x10 transfer, delivered from skid
        do_reset();
        fetch_n(4);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hABCD_0010);
        check("skid_hold_pc", pc_d, 32'hC);
        check("skid_req", {31'b0, imem_req}, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
        check("skid_hold2", pc_d, 32'hC);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2222_2222);
        check("skid_pc_d", pc_d, 32'h10);
        check("skid_instr", instr_d, 32'hABCD_0010);
        check("skid_next", imem_addr, 32'h14);

        // redirect while 0x20 pending
        do_reset();
        fetch_n(8);
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
        check("kill_addr", imem_addr, 32'h20);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0020);
        check("kill_next", imem_addr, 32'h100);
        check("kill_valid", {31'b0, valid_d}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0100);
        check("kill_pc_d", pc_d, 32'h100);

        // second redirect overwrites the stored target; low bits ignored
        do_reset();
        fetch_n(2);
        step(1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h503, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0008);
        check("kill2_addr", imem_addr, 32'h500);

        // redirect + flush + stall while skid full
        do_reset();
        fetch_n(4);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hABCD_0010);
        step(1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
        check("rfs_valid", {31'b0, valid_d}, 32'h0);
        check("rfs_addr", imem_addr, 32'h300);
        check("rfs_req", {31'b0, imem_req}, 32'h1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0300);
        check("rfs_pc_d", pc_d, 32'h300);

        // PC wrap
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h0);
        fetch_n(2);
        check("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4_d, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);

        // reset mid-request
        do_reset();
        fetch_n(2);
        imem_ready = 1'b0;
        #3;
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("post_rst_addr", imem_addr, 32'h0);

        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 13) == 0, $urandom,
                 $urandom_range(0, 9) < 6, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
